// File: rtl/pipeline_ctrl_v2_pkg.sv
// Shared encodings for the pipeline controller: forwarding sources, stage indices, debug states.
package pipeline_ctrl_v2_pkg;

  localparam logic [1:0] FWD_SRC_RF  = 2'd0;
  localparam logic [1:0] FWD_SRC_EXE = 2'd1;
  localparam logic [1:0] FWD_SRC_MEM = 2'd2;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EXE = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;
  localparam int unsigned NUM_STG = 5;

  localparam logic [1:0] DBG_RUN  = 2'd0;
  localparam logic [1:0] DBG_HALT = 2'd1;
  localparam logic [1:0] DBG_STEP = 2'd2;

endpackage

// File: rtl/pipeline_ctrl_v2_dbg_step_fsm.sv
// Debug run/halt/multi-step state machine with step-edge detection and step counter.
module pipeline_ctrl_v2_dbg_step_fsm
  import pipeline_ctrl_v2_pkg::*;
#(
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [STEP_W-1:0] debug_step_count,
  output logic [1:0]        state,
  output logic              dbg_halted
);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              step_prev_q, step_prev_d;
  logic              halted_q, halted_d;
  logic              step_rise;

  // Next-state, step counter and halted flag.
  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    step_prev_d = debug_step;
    step_rise   = debug_step && !step_prev_q;
    case (state_q)
      DBG_RUN: begin
        if (debug_en) state_d = DBG_HALT;
      end
      DBG_HALT: begin
        if (!debug_en) begin
          state_d = DBG_RUN;
        end else if (step_rise) begin
          state_d    = DBG_STEP;
          step_cnt_d = (debug_step_count == '0) ? STEP_W'(1) : debug_step_count;
        end
      end
      DBG_STEP: begin
        step_cnt_d = step_cnt_q - STEP_W'(1);
        if (!debug_en) begin
          state_d    = DBG_RUN;
          step_cnt_d = '0;
        end else if (step_cnt_q == STEP_W'(1)) begin
          state_d = DBG_HALT;
        end
      end
      default: begin
        state_d    = DBG_RUN;
        step_cnt_d = '0;
      end
    endcase
    halted_d = (state_d == DBG_HALT);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DBG_RUN;
      step_cnt_q  <= '0;
      step_prev_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      step_prev_q <= step_prev_d;
      halted_q    <= halted_d;
    end
  end

  assign state      = state_q;
  assign dbg_halted = halted_q;

endmodule

// File: rtl/pipeline_ctrl_v2.sv
// Pipeline controller: operand forwarding, load-use/RAW stalls, branch flush/hold, debug gating, perf counters.
module pipeline_ctrl_v2
  import pipeline_ctrl_v2_pkg::*;
#(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned FWD_EN        = 1,
  parameter int unsigned BR_PREDICT_NT = 1,
  parameter int unsigned STEP_W        = 8,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic [REG_AW-1:0] addr_rs,
  input  logic [REG_AW-1:0] addr_rt,
  input  logic              is_branch_id,
  input  logic              is_branch_exe,
  input  logic              is_branch_mem,
  input  logic              branch_taken_exe,
  input  logic [REG_AW-1:0] regw_addr_exe,
  input  logic              wb_wen_exe,
  input  logic              mem_ren_exe,
  input  logic [REG_AW-1:0] regw_addr_mem,
  input  logic              wb_wen_mem,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [STEP_W-1:0] debug_step_count,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [4:0]        stage_en,
  output logic [4:0]        stage_rst,
  output logic              dbg_halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [1:0]       dbg_state;
  logic             exe_a, exe_b, mem_a, mem_b;
  logic             stall, flush, hold, in_halt;
  logic             stall_act, flush_act;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  pipeline_ctrl_v2_dbg_step_fsm #(
    .STEP_W (STEP_W)
  ) u_dbg (
    .clk              (clk),
    .rst              (rst),
    .debug_en         (debug_en),
    .debug_step       (debug_step),
    .debug_step_count (debug_step_count),
    .state            (dbg_state),
    .dbg_halted       (dbg_halted)
  );

  // Hazard detection, forwarding selects, stage control and counter updates.
  always_comb begin
    exe_a = rs_used && (addr_rs != '0) && wb_wen_exe && (regw_addr_exe == addr_rs);
    exe_b = rt_used && (addr_rt != '0) && wb_wen_exe && (regw_addr_exe == addr_rt);
    mem_a = rs_used && (addr_rs != '0) && wb_wen_mem && (regw_addr_mem == addr_rs);
    mem_b = rt_used && (addr_rt != '0) && wb_wen_mem && (regw_addr_mem == addr_rt);
    in_halt = (dbg_state == DBG_HALT);

    if (FWD_EN != 0) stall = (exe_a || exe_b) && mem_ren_exe;
    else             stall = exe_a || exe_b || mem_a || mem_b;
    flush = (BR_PREDICT_NT != 0) && is_branch_exe && branch_taken_exe;
    hold  = (BR_PREDICT_NT == 0) && (is_branch_id || is_branch_exe || is_branch_mem) && !stall;

    fwd_a_sel = FWD_SRC_RF;
    fwd_b_sel = FWD_SRC_RF;
    stage_en  = '1;
    stage_rst = '0;
    stall_act = 1'b0;
    flush_act = 1'b0;

    if (rst) begin
      stage_rst = '1;
    end else if (in_halt) begin
      stage_en = '0;
    end else begin
      if (FWD_EN != 0) begin
        fwd_a_sel = exe_a ? FWD_SRC_EXE : (mem_a ? FWD_SRC_MEM : FWD_SRC_RF);
        fwd_b_sel = exe_b ? FWD_SRC_EXE : (mem_b ? FWD_SRC_MEM : FWD_SRC_RF);
      end
      if (flush) begin
        // IF stays enabled so the redirected PC loads; ID and EXE are squashed.
        stage_rst[STG_ID]  = 1'b1;
        stage_rst[STG_EXE] = 1'b1;
        flush_act          = 1'b1;
      end else if (stall) begin
        stage_en[STG_IF]   = 1'b0;
        stage_en[STG_ID]   = 1'b0;
        stage_rst[STG_EXE] = 1'b1;
        stall_act          = 1'b1;
      end else if (hold) begin
        stage_rst[STG_ID] = 1'b1;
      end
    end

    stall_cnt_d = stall_act ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = flush_act ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // Performance counters, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_v2.sv
// Directed bench: vector table for hazard/forwarding/branch logic plus debug and reset sequences.
module tb_pipeline_ctrl_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs_used, rt_used;
  logic [4:0] addr_rs, addr_rt;
  logic       is_branch_id, is_branch_exe, is_branch_mem, branch_taken_exe;
  logic [4:0] regw_addr_exe, regw_addr_mem;
  logic       wb_wen_exe, mem_ren_exe, wb_wen_mem;
  logic       debug_en, debug_step;
  logic [7:0] debug_step_count;

  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a_sel0, fwd_b_sel0;
  logic [4:0]  stage_en, stage_rst, stage_en0, stage_rst0;
  logic        dbg_halted, dbg_halted0;
  logic [31:0] stall_cnt, flush_cnt, stall_cnt0, flush_cnt0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_v2 dut (
    .clk(clk), .rst(rst), .rs_used(rs_used), .rt_used(rt_used),
    .addr_rs(addr_rs), .addr_rt(addr_rt), .is_branch_id(is_branch_id),
    .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
    .branch_taken_exe(branch_taken_exe), .regw_addr_exe(regw_addr_exe),
    .wb_wen_exe(wb_wen_exe), .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem),
    .wb_wen_mem(wb_wen_mem), .debug_en(debug_en), .debug_step(debug_step),
    .debug_step_count(debug_step_count), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stage_en(stage_en), .stage_rst(stage_rst), .dbg_halted(dbg_halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl_v2 #(.FWD_EN(0), .BR_PREDICT_NT(0)) dut0 (
    .clk(clk), .rst(rst), .rs_used(rs_used), .rt_used(rt_used),
    .addr_rs(addr_rs), .addr_rt(addr_rt), .is_branch_id(is_branch_id),
    .is_branch_exe(is_branch_exe), .is_branch_mem(is_branch_mem),
    .branch_taken_exe(branch_taken_exe), .regw_addr_exe(regw_addr_exe),
    .wb_wen_exe(wb_wen_exe), .mem_ren_exe(mem_ren_exe), .regw_addr_mem(regw_addr_mem),
    .wb_wen_mem(wb_wen_mem), .debug_en(debug_en), .debug_step(debug_step),
    .debug_step_count(debug_step_count), .fwd_a_sel(fwd_a_sel0), .fwd_b_sel(fwd_b_sel0),
    .stage_en(stage_en0), .stage_rst(stage_rst0), .dbg_halted(dbg_halted0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  // used = {rs_used, rt_used}; exe = {wb_wen_exe, mem_ren_exe};
  // ctl = {wb_wen_mem, is_branch_id, is_branch_exe, is_branch_mem, branch_taken_exe};
  // inc = {stall_cnt step, flush_cnt step} for dut; en0/srst0/st0 for the FWD_EN=0, BR_PREDICT_NT=0 copy.
  typedef struct {
    logic [1:0] used;
    logic [4:0] a_rs, a_rt;
    logic [1:0] exe;
    logic [4:0] w_exe;
    logic [4:0] ctl;
    logic [4:0] w_mem;
    logic [1:0] fa, fb;
    logic [4:0] en, srst;
    logic [1:0] inc;
    logic [4:0] en0, srst0;
    logic       st0;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {rs_used, rt_used, wb_wen_exe, mem_ren_exe, wb_wen_mem} = '0;
    {is_branch_id, is_branch_exe, is_branch_mem, branch_taken_exe} = '0;
    addr_rs = '0; addr_rt = '0; regw_addr_exe = '0; regw_addr_mem = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count RUN-like cycles (all stages enabled) until the FSM returns to HALT.
  task automatic run_steps(input string nm, input int exp_n);
    int  n = 0;
    bit  done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (dbg_halted) done = 1'b1;
      else if (stage_en == 5'b11111) n++;
    end
    chk({nm, "_back_to_halt"}, 32'(done), 32'd1);
    chk({nm, "_cycles"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_stall = 0, exp_flush = 0, exp_stall0 = 0;

    vecs[0]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'b00000, 5'd0, 2'd0, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11111, 5'b00000, 1'b0};
    vecs[1]  = '{2'b10, 5'd3, 5'd0, 2'b10, 5'd3, 5'b00000, 5'd0, 2'd1, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11100, 5'b00100, 1'b1};
    vecs[2]  = '{2'b01, 5'd0, 5'd5, 2'b11, 5'd5, 5'b00000, 5'd0, 2'd0, 2'd1, 5'b11100, 5'b00100, 2'b10, 5'b11100, 5'b00100, 1'b1};
    vecs[3]  = '{2'b01, 5'd0, 5'd5, 2'b00, 5'd0, 5'b10000, 5'd5, 2'd0, 2'd2, 5'b11111, 5'b00000, 2'b00, 5'b11100, 5'b00100, 1'b1};
    vecs[4]  = '{2'b10, 5'd7, 5'd0, 2'b10, 5'd7, 5'b10000, 5'd7, 2'd1, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11100, 5'b00100, 1'b1};
    vecs[5]  = '{2'b11, 5'd0, 5'd0, 2'b11, 5'd0, 5'b10000, 5'd0, 2'd0, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11111, 5'b00000, 1'b0};
    vecs[6]  = '{2'b00, 5'd6, 5'd6, 2'b11, 5'd6, 5'b10000, 5'd6, 2'd0, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11111, 5'b00000, 1'b0};
    vecs[7]  = '{2'b10, 5'd4, 5'd0, 2'b11, 5'd4, 5'b00101, 5'd0, 2'd1, 2'd0, 5'b11111, 5'b00110, 2'b01, 5'b11100, 5'b00100, 1'b1};
    vecs[8]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'b00100, 5'd0, 2'd0, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11111, 5'b00010, 1'b0};
    vecs[9]  = '{2'b11, 5'd2, 5'd9, 2'b10, 5'd9, 5'b10000, 5'd2, 2'd2, 2'd1, 5'b11111, 5'b00000, 2'b00, 5'b11100, 5'b00100, 1'b1};
    vecs[10] = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'b01000, 5'd0, 2'd0, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11111, 5'b00010, 1'b0};
    vecs[11] = '{2'b10, 5'd8, 5'd0, 2'b00, 5'd0, 5'b00000, 5'd8, 2'd0, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11111, 5'b00000, 1'b0};
    vecs[12] = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'b00010, 5'd0, 2'd0, 2'd0, 5'b11111, 5'b00000, 2'b00, 5'b11111, 5'b00010, 1'b0};
    vecs[13] = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'b00101, 5'd0, 2'd0, 2'd0, 5'b11111, 5'b00110, 2'b01, 5'b11111, 5'b00010, 1'b0};

    // Reset with a live forwarding match on the inputs: everything must be forced.
    rst = 1'b1; debug_en = 1'b0; debug_step = 1'b0; debug_step_count = 8'd0;
    clear_inputs();
    rs_used = 1'b1; addr_rs = 5'd3; wb_wen_exe = 1'b1; regw_addr_exe = 5'd3; mem_ren_exe = 1'b1;
    tick(); tick();
    chk("rst_stage_rst", 32'(stage_rst), 32'h1f);
    chk("rst_stage_en", 32'(stage_en), 32'h1f);
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_halted", 32'(dbg_halted), 32'd0);
    rst = 1'b0;
    clear_inputs();
    tick();

    for (int i = 0; i < NV; i++) begin
      {rs_used, rt_used} = vecs[i].used;
      addr_rs = vecs[i].a_rs;
      addr_rt = vecs[i].a_rt;
      {wb_wen_exe, mem_ren_exe} = vecs[i].exe;
      regw_addr_exe = vecs[i].w_exe;
      {wb_wen_mem, is_branch_id, is_branch_exe, is_branch_mem, branch_taken_exe} = vecs[i].ctl;
      regw_addr_mem = vecs[i].w_mem;
      #1;
      chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a_sel), 32'(vecs[i].fa));
      chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b_sel), 32'(vecs[i].fb));
      chk($sformatf("v%0d_stage_en", i), 32'(stage_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_stage_rst", i), 32'(stage_rst), 32'(vecs[i].srst));
      chk($sformatf("v%0d_nofwd_a", i), 32'(fwd_a_sel0), 32'd0);
      chk($sformatf("v%0d_nofwd_stage_en", i), 32'(stage_en0), 32'(vecs[i].en0));
      chk($sformatf("v%0d_nofwd_stage_rst", i), 32'(stage_rst0), 32'(vecs[i].srst0));
      exp_stall  += int'(vecs[i].inc[1]);
      exp_flush  += int'(vecs[i].inc[0]);
      exp_stall0 += int'(vecs[i].st0);
      tick();
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, 32'(exp_stall));
      chk($sformatf("v%0d_flush_cnt", i), flush_cnt, 32'(exp_flush));
      chk($sformatf("v%0d_nofwd_stall_cnt", i), stall_cnt0, 32'(exp_stall0));
      chk($sformatf("v%0d_nofwd_flush_cnt", i), flush_cnt0, 32'd0);
    end
    clear_inputs();

    // Halt: stages gated, hazards masked, counters hold.
    debug_en = 1'b1;
    tick();
    chk("halt_flag", 32'(dbg_halted), 32'd1);
    chk("halt_stage_en", 32'(stage_en), 32'd0);
    chk("halt_stage_rst", 32'(stage_rst), 32'd0);
    rt_used = 1'b1; addr_rt = 5'd5; wb_wen_exe = 1'b1; regw_addr_exe = 5'd5; mem_ren_exe = 1'b1;
    is_branch_exe = 1'b1; branch_taken_exe = 1'b1;
    #1;
    chk("halt_masked_rst", 32'(stage_rst), 32'd0);
    tick();
    chk("halt_stall_hold", stall_cnt, 32'(exp_stall));
    chk("halt_flush_hold", flush_cnt, 32'(exp_flush));
    clear_inputs();

    // Multi-step of 3 cycles, then count 0 behaves as a single step.
    debug_step_count = 8'd3; debug_step = 1'b1;
    run_steps("step3", 3);
    debug_step = 1'b0;
    tick();
    debug_step_count = 8'd0; debug_step = 1'b1;
    run_steps("step0", 1);

    // Reset in the middle of a step.
    debug_step = 1'b0;
    tick();
    debug_step_count = 8'd5; debug_step = 1'b1;
    tick();
    chk("midstep_running", 32'(stage_en), 32'h1f);
    rst = 1'b1;
    #1;
    chk("midstep_rst_stage_rst", 32'(stage_rst), 32'h1f);
    tick();
    chk("midstep_rst_held", 32'(stage_rst), 32'h1f);
    chk("midstep_halted", 32'(dbg_halted), 32'd0);
    chk("midstep_stall_cnt", stall_cnt, 32'd0);
    chk("midstep_flush_cnt", flush_cnt, 32'd0);
    debug_en = 1'b0; debug_step = 1'b0; rst = 1'b0;
    #1;
    chk("post_rst_stage_en", 32'(stage_en), 32'h1f);
    chk("post_rst_stage_rst", 32'(stage_rst), 32'd0);
    tick();
    chk("post_rst_run", 32'(dbg_halted), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl_v2.md
Name: pipeline_ctrl_v2

Overview:
Parametrised pipeline controller for the 5-stage MIPS core (IF, ID, EXE, MEM, WB). It replaces stall-only hazard handling with operand forwarding and load-use detection, and offers two branch-handling modes. It also provides a debug run/halt/multi-step FSM and hazard performance counters. It sits beside the decoder and drives per-stage enable/reset vectors and the ID-stage forwarding muxes.

Parameters:
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding enabled; 0 = stall on any RAW hazard against EXE/MEM
BR_PREDICT_NT, 1, 1 = predict not-taken and flush on taken; 0 = hold IF/ID while any branch is in flight
STEP_W, 8, width of the debug step-count field
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rs_used  in  1  ID instruction reads rs
rt_used  in  1  ID instruction reads rt
addr_rs  in  REG_AW  ID rs address
addr_rt  in  REG_AW  ID rt address
is_branch_id  in  1  ID instruction is a jump/branch
is_branch_exe  in  1  EXE instruction is a jump/branch
is_branch_mem  in  1  MEM instruction is a jump/branch
branch_taken_exe  in  1  EXE branch resolved taken (valid when is_branch_exe=1)
regw_addr_exe  in  REG_AW  EXE destination register
wb_wen_exe  in  1  EXE writes a register
mem_ren_exe  in  1  EXE instruction is a load
regw_addr_mem  in  REG_AW  MEM destination register
wb_wen_mem  in  1  MEM writes a register
debug_en  in  1  halt request
debug_step  in  1  step request (level; acted on at its rising edge)
debug_step_count  in  STEP_W  number of cycles per step
fwd_a_sel  out  2  rs source: 0 = regfile, 1 = EXE result, 2 = MEM result
fwd_b_sel  out  2  rt source, same encoding
stage_en  out  5  per-stage enable, bit0 = IF … bit4 = WB
stage_rst  out  5  per-stage reset, same bit order
dbg_halted  out  1  FSM is in HALT
stall_cnt  out  CNT_W  cycles with a load-use/RAW stall
flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Reset (synchronous): FSM goes to RUN; step counter = 0; debug_step_prev = 0; both counters = 0.
- While rst=1: stage_rst = 5'b11111, stage_en = 5'b11111, fwd_*_sel = 0.
- Outputs are combinational from the current state and inputs. Counters and FSM update on posedge clk.
- Forwarding, for each operand X in {rs, rt} with X_used=1 and addr_X != 0:
  - EXE match (wb_wen_exe && regw_addr_exe == addr_X) takes priority: sel = 1.
  - Otherwise, MEM match: sel = 2.
  - Otherwise: sel = 0.
  - When FWD_EN=0, sel is always 0.
- Hazard stall:
  - FWD_EN=1: stall when an EXE match exists and mem_ren_exe=1 (load-use).
  - FWD_EN=0: stall on any EXE or MEM match.
  - Stall action: stage_en[1:0] = 0 and stage_rst[2] = 1 (bubble inserted into EXE).
- Branch, BR_PREDICT_NT=1:
  - When is_branch_exe && branch_taken_exe: stage_rst[1] = 1 and stage_rst[2] = 1, flushing the two younger instructions.
  - A flush overrides a stall in the same cycle.
  - IF stays enabled so the redirected PC loads.
- Branch, BR_PREDICT_NT=0:
  - If is_branch_id, is_branch_exe or is_branch_mem is set and no stall is active: stage_rst[1] = 1.
  - This matches legacy behaviour: ID is bubbled while the branch resolves.
- Priority, highest first: rst, debug gating, branch flush, stall, branch hold.
- Debug FSM states: RUN, HALT, STEP.
  - RUN → HALT when debug_en=1.
  - HALT → RUN when debug_en=0.
  - HALT → STEP on a step rising edge (debug_step && !debug_step_prev). The step counter loads max(debug_step_count, 1).
  - STEP decrements the counter every cycle. When the counter is 1 and debug_en=1, go to HALT. If debug_en=0 during STEP, go to RUN immediately.
  - In HALT, stage_en = 0 and stage_rst = 0, and hazard/branch logic is masked.
  - In STEP, outputs are identical to RUN.
- dbg_halted = 1 only in HALT.
- Counters:
  - stall_cnt increments in any non-HALT cycle where the stall action is applied.
  - flush_cnt increments on each predict-not-taken flush cycle. It never increments when BR_PREDICT_NT=0.
  - Both counters wrap modulo 2^CNT_W.
  - Both hold while halted.
- No forwarding or stall is ever generated for register 0.

Decomposition:
- Shared package (extend mips_define.vh):
  - FWD_SRC_RF/EXE/MEM encodings.
  - Stage index constants STG_IF..STG_WB.
  - DBG_RUN/HALT/STEP state encodings.
- One natural sub-module: dbg_step_fsm. It takes debug_en, debug_step and debug_step_count and produces state and dbg_halted.
- Forwarding and hazard logic stay inline.

Test Plan:
- Forward from EXE: add r3 in EXE (wb_wen_exe=1, regw=3, mem_ren_exe=0), ID rs=3 → fwd_a_sel=1, stage_en=11111, stall_cnt unchanged.
- Load-use: lw r5 in EXE (mem_ren_exe=1, regw=5), ID rt=5 with rt_used=1 → stage_en[1:0]=00 and stage_rst[2]=1 for one cycle, stall_cnt=1. The next cycle (lw now in MEM) gives fwd_b_sel=2.
- Priority and r0:
  - EXE and MEM both write r7, ID rs=7 → fwd_a_sel=1.
  - addr_rs=0 with matching writers → fwd_a_sel=0 and no stall.
- Taken branch, BR_PREDICT_NT=1: is_branch_exe=1 and branch_taken_exe=1, with a load-use stall also asserted → stage_rst=5'b00110, stage_en[1:0]=11, flush_cnt=1, stall_cnt unchanged.
- Debug step: debug_en=1 → next cycle dbg_halted=1, stage_en=0. Then step pulse with count=3 → exactly 3 cycles with stage_en=11111, then HALT. Count=0 gives exactly 1 cycle.
- Reset mid-step: rst during STEP → next cycle FSM in RUN, counters 0, stage_rst=11111 while rst is held.
